// File: rtl/ac_pkg.sv
// Shared types and sizes for the Aho-Corasick match sequencer.
package ac_pkg;

  localparam int STATE_W  = 8;
  localparam int CHAR_W   = 4;
  localparam int N_GOTO   = 32;
  localparam int GADDR_W  = 5;
  localparam int MAX_FAIL = 16;
  localparam int POS_W    = 16;
  // Hop counter must be able to hold MAX_FAIL itself.
  localparam int HOP_W    = $clog2(MAX_FAIL + 1);

  // Per-character sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_G_RD  = 3'd1,
    ST_G_CMP = 3'd2,
    ST_F_RD  = 3'd3,
    ST_F_CMP = 3'd4,
    ST_S_RD  = 3'd5,
    ST_S_CMP = 3'd6,
    ST_EMIT  = 3'd7
  } seq_state_t;

  // One goto-table entry: (current state, character) -> next state.
  typedef struct packed {
    logic [STATE_W-1:0] cur;
    logic [CHAR_W-1:0]  chara;
    logic [STATE_W-1:0] next;
  } goto_entry_t;

  // True when a goto entry applies to the given state/character pair.
  function automatic logic entry_hit(input goto_entry_t e,
                                     input logic [STATE_W-1:0] st,
                                     input logic [CHAR_W-1:0] ch);
    entry_hit = (e.cur == st) && (e.chara == ch);
  endfunction

endpackage

// File: rtl/ac_goto_scanner.sv
// Goto-table scan index plus the hit / last-entry compare for the sequencer.
module ac_goto_scanner
  import ac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               idx_clr,
  input  logic               idx_inc,
  input  goto_entry_t        entry,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [CHAR_W-1:0]  cur_char,
  output logic [GADDR_W-1:0] idx,
  output logic               hit,
  output logic               last,
  output logic [STATE_W-1:0] hit_next
);

  localparam logic [GADDR_W-1:0] LAST_IDX = GADDR_W'(N_GOTO - 1);

  logic [GADDR_W-1:0] idx_r;

  // Scan index: restart on a new character or failure hop, step on a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
    end else if (idx_clr) begin
      idx_r <= '0;
    end else if (idx_inc) begin
      idx_r <= idx_r + GADDR_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Compare the entry returned for idx_r against the automaton state/char.
  always_comb begin
    hit      = entry_hit(entry, cur_state, cur_char);
    last     = (idx_r == LAST_IDX);
    hit_next = entry.next;
  end

  assign idx = idx_r;

endmodule

// File: rtl/ac_match_sequencer.sv
// Per-character Aho-Corasick controller: goto scan, failure hops, output
// flag lookup and result reporting. Sole master of the table read ports.
module ac_match_sequencer
  import ac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               char_valid,
  input  logic [CHAR_W-1:0]  char_in,
  output logic               char_ready,
  output logic               g_rd,
  output logic [GADDR_W-1:0] g_addr,
  input  logic [STATE_W-1:0] g_cur,
  input  logic [CHAR_W-1:0]  g_chara,
  input  logic [STATE_W-1:0] g_next,
  output logic               s_rd,
  output logic [STATE_W-1:0] s_addr,
  input  logic [STATE_W-1:0] s_fail,
  input  logic               s_out,
  output logic               result_valid,
  output logic [STATE_W-1:0] now_state,
  output logic               match,
  output logic [POS_W-1:0]   pos,
  output logic               err
);

  localparam logic [HOP_W-1:0] HOP_LIMIT = HOP_W'(MAX_FAIL);

  seq_state_t         fsm_r, fsm_s;
  logic [STATE_W-1:0] ac_state_r, ac_state_s;
  logic [CHAR_W-1:0]  char_r, char_s;
  logic [HOP_W-1:0]   hops_r, hops_s;
  logic               err_flag_r, err_flag_s;
  logic [POS_W-1:0]   pos_cnt_r, pos_cnt_s;

  logic               char_ready_r, char_ready_s;
  logic               g_rd_r, g_rd_s;
  logic               s_rd_r, s_rd_s;
  logic               result_valid_r, result_valid_s;
  logic [STATE_W-1:0] now_state_r, now_state_s;
  logic               match_r, match_s;
  logic [POS_W-1:0]   pos_r, pos_s;
  logic               err_r, err_s;

  logic               idx_clr_s, idx_inc_s;
  logic [GADDR_W-1:0] scan_idx_s;
  logic               scan_hit_s, scan_last_s;
  logic [STATE_W-1:0] scan_next_s;
  goto_entry_t        entry_s;

  assign entry_s = '{cur: g_cur, chara: g_chara, next: g_next};

  ac_goto_scanner u_scanner (
    .clk       (clk),
    .rst       (rst),
    .idx_clr   (idx_clr_s),
    .idx_inc   (idx_inc_s),
    .entry     (entry_s),
    .cur_state (ac_state_r),
    .cur_char  (char_r),
    .idx       (scan_idx_s),
    .hit       (scan_hit_s),
    .last      (scan_last_s),
    .hit_next  (scan_next_s)
  );

  // Next-state logic: sequencing, automaton state update and result capture.
  always_comb begin
    fsm_s          = fsm_r;
    ac_state_s     = ac_state_r;
    char_s         = char_r;
    hops_s         = hops_r;
    err_flag_s     = err_flag_r;
    pos_cnt_s      = pos_cnt_r;
    idx_clr_s      = 1'b0;
    idx_inc_s      = 1'b0;
    result_valid_s = 1'b0;
    now_state_s    = now_state_r;
    match_s        = match_r;
    pos_s          = pos_r;
    err_s          = err_r;

    case (fsm_r)
      ST_IDLE: begin
        // CLEAR takes effect before a character offered in the same cycle.
        if (clear) begin
          ac_state_s = '0;
          pos_cnt_s  = '0;
          pos_s      = '0;
        end else begin
          ac_state_s = ac_state_r;
        end
        if (char_valid) begin
          char_s     = char_in;
          hops_s     = '0;
          err_flag_s = 1'b0;
          idx_clr_s  = 1'b1;
          fsm_s      = ST_G_RD;
        end else begin
          fsm_s = ST_IDLE;
        end
      end
      ST_G_RD: begin
        fsm_s = ST_G_CMP;
      end
      ST_G_CMP: begin
        if (scan_hit_s) begin
          ac_state_s = scan_next_s;
          fsm_s      = ST_S_RD;
        end else if (!scan_last_s) begin
          idx_inc_s = 1'b1;
          fsm_s     = ST_G_RD;
        end else if (ac_state_r == '0) begin
          // Root has no failure link: an unmatched char leaves us at root.
          fsm_s = ST_S_RD;
        end else begin
          fsm_s = ST_F_RD;
        end
      end
      ST_F_RD: begin
        fsm_s = ST_F_CMP;
      end
      ST_F_CMP: begin
        hops_s    = hops_r + HOP_W'(1);
        idx_clr_s = 1'b1;
        if ((hops_r + HOP_W'(1)) == HOP_LIMIT) begin
          // Runaway failure chain: abandon the character at the root.
          ac_state_s = '0;
          err_flag_s = 1'b1;
          fsm_s      = ST_S_RD;
        end else begin
          ac_state_s = s_fail;
          fsm_s      = ST_G_RD;
        end
      end
      ST_S_RD: begin
        fsm_s = ST_S_CMP;
      end
      ST_S_CMP: begin
        result_valid_s = 1'b1;
        now_state_s    = ac_state_r;
        match_s        = s_out;
        pos_s          = pos_cnt_r;
        err_s          = err_flag_r;
        fsm_s          = ST_EMIT;
      end
      ST_EMIT: begin
        pos_cnt_s = pos_cnt_r + POS_W'(1);
        fsm_s     = ST_IDLE;
      end
      default: begin
        fsm_s = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the upcoming state so they leave a register.
    char_ready_s = (fsm_s == ST_IDLE);
    g_rd_s       = (fsm_s == ST_G_RD);
    s_rd_s       = (fsm_s == ST_F_RD) || (fsm_s == ST_S_RD);
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r          <= ST_IDLE;
      ac_state_r     <= '0;
      char_r         <= '0;
      hops_r         <= '0;
      err_flag_r     <= 1'b0;
      pos_cnt_r      <= '0;
      char_ready_r   <= 1'b1;
      g_rd_r         <= 1'b0;
      s_rd_r         <= 1'b0;
      result_valid_r <= 1'b0;
      now_state_r    <= '0;
      match_r        <= 1'b0;
      pos_r          <= '0;
      err_r          <= 1'b0;
    end else begin
      fsm_r          <= fsm_s;
      ac_state_r     <= ac_state_s;
      char_r         <= char_s;
      hops_r         <= hops_s;
      err_flag_r     <= err_flag_s;
      pos_cnt_r      <= pos_cnt_s;
      char_ready_r   <= char_ready_s;
      g_rd_r         <= g_rd_s;
      s_rd_r         <= s_rd_s;
      result_valid_r <= result_valid_s;
      now_state_r    <= now_state_s;
      match_r        <= match_s;
      pos_r          <= pos_s;
      err_r          <= err_s;
    end
  end

  // Addresses come straight from registers that are stable across each
  // strobe/sample pair.
  assign g_addr       = scan_idx_s;
  assign s_addr       = ac_state_r;
  assign char_ready   = char_ready_r;
  assign g_rd         = g_rd_r;
  assign s_rd         = s_rd_r;
  assign result_valid = result_valid_r;
  assign now_state    = now_state_r;
  assign match        = match_r;
  assign pos          = pos_r;
  assign err          = err_r;

endmodule

// File: tb/tb_ac_match_sequencer.sv
// Self-checking bench for ac_match_sequencer: directed scenarios on a fixed
// automaton, then random tables and characters against a behavioural model.
module tb_ac_match_sequencer;

  localparam int NG       = 32;
  localparam int MAXF     = 16;
  localparam int WAIT_MAX = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       char_valid = 1'b0;
  logic [3:0] char_in = 4'd0;
  logic       char_ready;
  logic       g_rd;
  logic [4:0] g_addr;
  logic [7:0] g_cur = 8'd0;
  logic [3:0] g_chara = 4'd0;
  logic [7:0] g_next = 8'd0;
  logic       s_rd;
  logic [7:0] s_addr;
  logic [7:0] s_fail = 8'd0;
  logic       s_out = 1'b0;
  logic       result_valid;
  logic [7:0] now_state;
  logic       match;
  logic [15:0] pos;
  logic       err;

  // Table contents as the bench sees them.
  logic [7:0] t_cur   [NG];
  logic [3:0] t_chara [NG];
  logic [7:0] t_next  [NG];
  logic [7:0] t_fail  [256];
  logic       t_out   [256];

  int tests_run = 0;
  int tests_failed = 0;
  int m_state = 0;
  int m_pos = 0;

  ac_match_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .char_valid   (char_valid),
    .char_in      (char_in),
    .char_ready   (char_ready),
    .g_rd         (g_rd),
    .g_addr       (g_addr),
    .g_cur        (g_cur),
    .g_chara      (g_chara),
    .g_next       (g_next),
    .s_rd         (s_rd),
    .s_addr       (s_addr),
    .s_fail       (s_fail),
    .s_out        (s_out),
    .result_valid (result_valid),
    .now_state    (now_state),
    .match        (match),
    .pos          (pos),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Table RAMs with one-cycle registered reads.
  always @(posedge clk) begin
    if (g_rd) begin
      g_cur   <= t_cur[g_addr];
      g_chara <= t_chara[g_addr];
      g_next  <= t_next[g_addr];
    end
    if (s_rd) begin
      s_fail <= t_fail[s_addr];
      s_out  <= t_out[s_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural Aho-Corasick step: result state, error flag and cycle count.
  task automatic ref_step(input int st, input int ch, output int nst, output int e, output int cyc);
    int s, hops, k;
    bit done;
    s = st; hops = 0; cyc = 0; done = 0; nst = 0; e = 0;
    while (!done) begin
      k = -1;
      for (int i = 0; i < NG; i++)
        if (k < 0 && t_cur[i] == s[7:0] && t_chara[i] == ch[3:0]) k = i;
      if (k >= 0) begin
        cyc += 2 * (k + 1); nst = t_next[k]; done = 1;
      end else begin
        cyc += 2 * NG;
        if (s == 0) begin
          nst = 0; done = 1;
        end else begin
          hops++; cyc += 2;
          if (hops == MAXF) begin
            nst = 0; e = 1; done = 1;
          end else begin
            s = t_fail[s];
          end
        end
      end
    end
    cyc += 3;
  endtask

  // Offer one character, wait for its result and compare with the model.
  task automatic run_char(input int c, input bit with_clear);
    int n, w, exp_st, exp_err, exp_cyc;
    w = 0;
    @(negedge clk);
    while (!char_ready && w < WAIT_MAX) begin @(negedge clk); w++; end
    check_eq("ready_wait", char_ready, 1);
    if (with_clear) begin m_state = 0; m_pos = 0; end
    ref_step(m_state, c, exp_st, exp_err, exp_cyc);
    clear = with_clear; char_valid = 1'b1; char_in = c[3:0];
    @(posedge clk); #1;
    char_valid = 1'b0; clear = 1'b0;
    n = 1;
    @(negedge clk);
    while (!result_valid && n < WAIT_MAX) begin @(negedge clk); n++; end
    check_eq("result_seen", result_valid, 1);
    check_eq("latency", n, exp_cyc);
    check_eq("now_state", now_state, exp_st);
    check_eq("match", match, t_out[exp_st]);
    check_eq("pos", pos, m_pos & 16'hFFFF);
    check_eq("err", err, exp_err);
    @(negedge clk);
    check_eq("pulse_len", result_valid, 0);
    check_eq("ready_back", char_ready, 1);
    check_eq("hold_state", now_state, exp_st);
    m_state = exp_st;
    m_pos = (m_pos + 1) & 16'hFFFF;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, char_ready, 1);
    check_eq({tag, "_grd"}, g_rd, 0);
    check_eq({tag, "_srd"}, s_rd, 0);
    check_eq({tag, "_gaddr"}, g_addr, 0);
    check_eq({tag, "_saddr"}, s_addr, 0);
    check_eq({tag, "_rv"}, result_valid, 0);
    check_eq({tag, "_state"}, now_state, 0);
    check_eq({tag, "_match"}, match, 0);
    check_eq({tag, "_pos"}, pos, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    int seen;
    // Directed automaton.
    for (int i = 0; i < NG; i++) begin
      t_cur[i] = 8'hFF; t_chara[i] = 4'd0; t_next[i] = 8'd0;
    end
    for (int i = 0; i < 256; i++) begin
      t_fail[i] = 8'd0; t_out[i] = 1'b0;
    end
    t_cur[0] = 8'd1; t_chara[0] = 4'd3;  t_next[0] = 8'd2;
    t_cur[1] = 8'd0; t_chara[1] = 4'd11; t_next[1] = 8'd1;
    t_cur[2] = 8'd2; t_chara[2] = 4'd5;  t_next[2] = 8'd3;
    t_fail[3] = 8'd1;
    t_out[3] = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Chain 11,3,5 builds up to the accepting state 3.
    run_char(11, 0);
    run_char(3, 0);
    run_char(5, 0);
    check_eq("accept_3", m_state, 3);
    // Miss from state 3 falls back to 1 and then hits e0.
    run_char(3, 0);

    // CLEAR in IDLE zeroes the position.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("clear_pos", pos, 0);
    m_state = 0; m_pos = 0;
    // Full miss from the root.
    run_char(7, 0);

    // Self-looping failure link forces the hop-limit abort.
    run_char(11, 0);
    t_fail[1] = 8'd1;
    run_char(7, 0);
    t_fail[1] = 8'd0;

    // CLEAR together with a character: character starts from the root.
    run_char(11, 0);
    run_char(11, 1);

    // Reset while the first goto entry is being compared.
    @(negedge clk);
    char_valid = 1'b1; char_in = 4'd11;
    @(posedge clk); #1;
    char_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    check_eq("no_result_after_rst", seen, 0);
    m_state = 0; m_pos = 0;
    run_char(11, 0);

    // Random automata and text.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < NG; i++) begin
        t_cur[i]   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
        t_chara[i] = 4'($urandom_range(0, 15));
        t_next[i]  = 8'($urandom_range(0, 5));
      end
      t_fail[0] = 8'd0;
      for (int s = 1; s < 6; s++) t_fail[s] = 8'($urandom_range(0, 5));
      for (int s = 0; s < 6; s++) t_out[s] = 1'($urandom_range(0, 1));
      run_char($urandom_range(0, 15), 1);
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_char($urandom_range(0, 15), ($urandom_range(0, 7) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
